// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game flow controller.
package game_pkg;

    localparam int STATE_W                   = 3;
    localparam int DEFAULT_COUNTDOWN_SECONDS = 3;
    localparam int DEFAULT_GAME_SECONDS      = 180;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        RUN       = 3'd2,
        PAUSE     = 3'd3,
        GAMEOVER  = 3'd4
    } state_t;

endpackage

// File: rtl/button_edge.sv
// Two-flop synchroniser for a raw button followed by a one-cycle rising-edge pulse.
module button_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [1:0] sync;
    logic       prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            prev <= sync[1];
        end
    end

    assign pulse = sync[1] && !prev;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: start countdown, run/pause, end-of-game detection and
// one-grant-per-second arbitration of player abilities.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int COUNTDOWN_SECONDS = DEFAULT_COUNTDOWN_SECONDS,
    parameter int GAME_SECONDS      = DEFAULT_GAME_SECONDS
) (
    input  logic               CLOCK_50,
    input  logic               resetN,
    input  logic               tick_1s,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               player_caught,
    input  logic               req_blackout,
    input  logic               req_build,
    output logic               master_enable,
    output logic               grant_blackout,
    output logic               grant_build,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         countdown,
    output logic [7:0]         time_left,
    output logic               game_over,
    output logic               win
);

    localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_SECONDS);
    localparam logic [7:0] TIME_INIT = 8'(GAME_SECONDS);

    state_t st;
    logic   start_edge, pause_edge;
    logic   pend_blackout, pend_build, window_open, last_blackout;

    button_edge u_start (
        .clk   (CLOCK_50),
        .rst_n (resetN),
        .raw   (start_btn),
        .pulse (start_edge)
    );

    button_edge u_pause (
        .clk   (CLOCK_50),
        .rst_n (resetN),
        .raw   (pause_btn),
        .pulse (pause_edge)
    );

    logic in_run, final_tick, stay_run, win_now, want_b, want_g, pick_b, pick_g;

    // A grant may only be issued in a RUN cycle that does not also leave RUN.
    always_comb begin
        in_run     = (st == RUN);
        final_tick = tick_1s && (time_left == 8'd1);
        stay_run   = in_run && !(player_caught || final_tick || pause_edge);
        win_now    = stay_run && (window_open || tick_1s);
        want_b     = pend_blackout || req_blackout;
        want_g     = pend_build || req_build;
        pick_b     = win_now && want_b && (!want_g || !last_blackout);
        pick_g     = win_now && want_g && !pick_b;
    end

    assign master_enable = in_run;
    assign game_over     = (st == GAMEOVER);
    assign state         = st;

    always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
            st             <= IDLE;
            countdown      <= CD_INIT;
            time_left      <= TIME_INIT;
            win            <= 1'b0;
            grant_blackout <= 1'b0;
            grant_build    <= 1'b0;
            pend_blackout  <= 1'b0;
            pend_build     <= 1'b0;
            window_open    <= 1'b0;
            last_blackout  <= 1'b0;
        end else begin
            grant_blackout <= pick_b;
            grant_build    <= pick_g;
            if (pick_b || pick_g) begin
                last_blackout <= pick_b;
            end
            pend_blackout <= stay_run && want_b && !pick_b;
            pend_build    <= stay_run && want_g && !pick_g;
            window_open   <= win_now && !(pick_b || pick_g);

            case (st)
                IDLE: begin
                    if (start_edge) begin
                        st        <= COUNTDOWN;
                        countdown <= CD_INIT;
                        time_left <= TIME_INIT;
                        win       <= 1'b0;
                    end
                end
                COUNTDOWN: begin
                    if (tick_1s) begin
                        if ((countdown == 4'd1) || (countdown == 4'd0)) begin
                            countdown <= 4'd0;
                            st        <= RUN;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                RUN: begin
                    if (player_caught) begin
                        st  <= GAMEOVER;
                        win <= 1'b0;
                    end else if (tick_1s) begin
                        time_left <= (time_left == 8'd0) ? 8'd0 : time_left - 8'd1;
                        if (final_tick) begin
                            st  <= GAMEOVER;
                            win <= 1'b1;
                        end else if (pause_edge) begin
                            st <= PAUSE;
                        end
                    end else if (pause_edge) begin
                        st <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause_edge || start_edge) begin
                        st <= RUN;
                    end
                end
                GAMEOVER: begin
                    if (start_edge) begin
                        st        <= IDLE;
                        countdown <= CD_INIT;
                        time_left <= TIME_INIT;
                        win       <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: countdown, pause, arbitration, end of game, reset.
module tb_game_flow_controller;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tick_1s = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       player_caught = 1'b0;
    logic       req_blackout = 1'b0;
    logic       req_build = 1'b0;
    logic       master_enable, grant_blackout, grant_build, game_over, win;
    logic [2:0] state;
    logic [3:0] countdown;
    logic [7:0] time_left;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    game_flow_controller dut (
        .CLOCK_50       (clk),
        .resetN         (resetN),
        .tick_1s        (tick_1s),
        .start_btn      (start_btn),
        .pause_btn      (pause_btn),
        .player_caught  (player_caught),
        .req_blackout   (req_blackout),
        .req_build      (req_build),
        .master_enable  (master_enable),
        .grant_blackout (grant_blackout),
        .grant_build    (grant_build),
        .state          (state),
        .countdown      (countdown),
        .time_left      (time_left),
        .game_over      (game_over),
        .win            (win)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
        step(1);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
        step(3);
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        step(3);
        pause_btn = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        step(2);
        if ({state, countdown, time_left} !== {3'd0, 4'd3, 8'd180}) begin
            errors++;
            $display("FAIL reset_values: state=%0d countdown=%0d time_left=%0d expected 0/3/180",
                     state, countdown, time_left);
        end
        checks++;
        if ({master_enable, grant_blackout, grant_build, game_over, win} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: me/gb/gg/go/win=%b expected 00000",
                     {master_enable, grant_blackout, grant_build, game_over, win});
        end
        checks++;
        resetN = 1'b1;
        step(2);
    endtask

    task automatic test_start_countdown();
        start_btn = 1'b1;
        step(2);
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL start_latency_early: state=%0d expected 0", state);
        end
        checks++;
        step(1);
        if (state !== 3'd1 || countdown !== 4'd3) begin
            errors++;
            $display("FAIL start_to_countdown: state=%0d countdown=%0d expected 1/3", state, countdown);
        end
        checks++;
        start_btn = 1'b1;
        step(4);
        start_btn = 1'b0;
        step(3);
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL start_hold_no_repeat: state=%0d expected 1", state);
        end
        checks++;
        do_tick();
        press_pause();
        if (state !== 3'd1 || countdown !== 4'd2) begin
            errors++;
            $display("FAIL countdown_pause_ignored: state=%0d countdown=%0d expected 1/2", state, countdown);
        end
        checks++;
        do_ticks(2);
        if ({state, countdown, time_left, master_enable} !== {3'd2, 4'd0, 8'd180, 1'b1}) begin
            errors++;
            $display("FAIL countdown_to_run: state=%0d countdown=%0d time_left=%0d me=%b expected 2/0/180/1",
                     state, countdown, time_left, master_enable);
        end
        checks++;
    endtask

    task automatic test_pause();
        do_ticks(130);
        if (time_left !== 8'd50) begin
            errors++;
            $display("FAIL run_count_to_50: time_left=%0d expected 50", time_left);
        end
        checks++;
        press_pause();
        do_ticks(5);
        if ({state, time_left, master_enable} !== {3'd3, 8'd50, 1'b0}) begin
            errors++;
            $display("FAIL pause_freeze: state=%0d time_left=%0d me=%b expected 3/50/0",
                     state, time_left, master_enable);
        end
        checks++;
        press_pause();
        if (state !== 3'd2 || master_enable !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: state=%0d me=%b expected 2/1", state, master_enable);
        end
        checks++;
        do_tick();
        if (time_left !== 8'd49) begin
            errors++;
            $display("FAIL resume_tick: time_left=%0d expected 49", time_left);
        end
        checks++;
    endtask

    task automatic test_arbitration();
        int cb;
        int cg;
        do_tick();
        req_blackout = 1'b1;
        req_build    = 1'b1;
        step(1);
        req_blackout = 1'b0;
        req_build    = 1'b0;
        cb = int'(grant_blackout);
        cg = int'(grant_build);
        for (int i = 0; i < 6; i++) begin
            step(1);
            cb += int'(grant_blackout);
            cg += int'(grant_build);
        end
        if (cb != 1 || cg != 0) begin
            errors++;
            $display("FAIL arb_first_window: blackout_pulses=%0d build_pulses=%0d expected 1/0", cb, cg);
        end
        checks++;
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
        if (grant_build !== 1'b1 || grant_blackout !== 1'b0) begin
            errors++;
            $display("FAIL arb_build_after_tick: grant_build=%b grant_blackout=%b expected 1/0",
                     grant_build, grant_blackout);
        end
        checks++;
        cb = 0;
        cg = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            cb += int'(grant_blackout);
            cg += int'(grant_build);
        end
        if (cb != 0 || cg != 0 || time_left !== 8'd47) begin
            errors++;
            $display("FAIL arb_no_repeat: blackout_pulses=%0d build_pulses=%0d time_left=%0d expected 0/0/47",
                     cb, cg, time_left);
        end
        checks++;
    endtask

    task automatic test_caught_on_final_tick();
        do_ticks(46);
        if (time_left !== 8'd1 || state !== 3'd2) begin
            errors++;
            $display("FAIL caught_setup: time_left=%0d state=%0d expected 1/2", time_left, state);
        end
        checks++;
        tick_1s       = 1'b1;
        player_caught = 1'b1;
        step(1);
        tick_1s       = 1'b0;
        player_caught = 1'b0;
        if ({state, game_over, win, master_enable} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL caught_priority: state=%0d go=%b win=%b me=%b expected 4/1/0/0",
                     state, game_over, win, master_enable);
        end
        checks++;
    endtask

    task automatic test_timeout();
        press_start();
        if ({state, countdown, time_left} !== {3'd0, 4'd3, 8'd180}) begin
            errors++;
            $display("FAIL gameover_to_idle: state=%0d countdown=%0d time_left=%0d expected 0/3/180",
                     state, countdown, time_left);
        end
        checks++;
        press_start();
        do_ticks(3);
        do_ticks(179);
        if (state !== 3'd2 || time_left !== 8'd1) begin
            errors++;
            $display("FAIL timeout_before_last: state=%0d time_left=%0d expected 2/1", state, time_left);
        end
        checks++;
        do_tick();
        if ({state, time_left, game_over, win, master_enable} !== {3'd4, 8'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_win: state=%0d time_left=%0d go=%b win=%b me=%b expected 4/0/1/1/0",
                     state, time_left, game_over, win, master_enable);
        end
        checks++;
        do_ticks(2);
        if (time_left !== 8'd0 || win !== 1'b1) begin
            errors++;
            $display("FAIL gameover_hold: time_left=%0d win=%b expected 0/1", time_left, win);
        end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        int cg;
        press_start();
        press_start();
        do_ticks(3);
        req_build = 1'b1;
        step(1);
        req_build = 1'b0;
        step(1);
        if (state !== 3'd2 || grant_build !== 1'b0) begin
            errors++;
            $display("FAIL pending_no_window: state=%0d grant_build=%b expected 2/0", state, grant_build);
        end
        checks++;
        resetN = 1'b0;
        #1;
        if ({state, countdown, time_left, master_enable} !== {3'd0, 4'd3, 8'd180, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: state=%0d countdown=%0d time_left=%0d me=%b expected 0/3/180/0",
                     state, countdown, time_left, master_enable);
        end
        checks++;
        step(2);
        resetN = 1'b1;
        step(2);
        press_start();
        do_ticks(3);
        cg = 0;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            cg += int'(grant_build);
            step(1);
            cg += int'(grant_build);
        end
        if (cg != 0 || state !== 3'd2) begin
            errors++;
            $display("FAIL no_stale_grant: build_pulses=%0d state=%0d expected 0/2", cg, state);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_start_countdown();
        test_pause();
        test_arbitration();
        test_caught_on_final_tick();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the UI layer. It owns the master-enable that gates the game-time counter and both cooldown counters.
- Runs the start countdown, pause/resume, and end-of-game detection.
- Arbitrates player ability requests (blackout, gate build) so at most one ability is granted per one-second tick.
- Sits between the KEY inputs / one-second enable and the existing UI counter blocks.

Parameters:
- COUNTDOWN_SECONDS, 3, pre-game countdown length in ticks (1..15).
- GAME_SECONDS, 180, game length in ticks (1..255).

Ports:
- CLOCK_50  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- tick_1s  in  1  one-cycle enable pulse, once per second.
- start_btn  in  1  active-high raw button.
- pause_btn  in  1  active-high raw button.
- player_caught  in  1  level; loss condition from game logic.
- req_blackout  in  1  pulse or level; blackout ability request.
- req_build  in  1  pulse or level; gate-build request, already qualified by canBuild.
- master_enable  out  1  high only in RUN.
- grant_blackout  out  1  one-cycle grant pulse.
- grant_build  out  1  one-cycle grant pulse.
- state  out  3  encoded FSM state.
- countdown  out  4  remaining countdown seconds, for HEX display.
- time_left  out  8  remaining game seconds.
- game_over  out  1  high in GAMEOVER.
- win  out  1  valid when game_over; 1 = survived to time-out.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; all outputs 0 except countdown=COUNTDOWN_SECONDS and time_left=GAME_SECONDS.
  - Pending flags, last-grant pointer and synchronisers cleared.
  - Reset mid-operation aborts everything immediately.
- Button conditioning:
  - start_btn and pause_btn each pass through a 2-flop synchroniser, then rising-edge detection.
  - The edge pulse is one cycle and occurs 3 cycles after the raw rise.
  - Holding a button produces no repeat.
- States (encoding): IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, GAMEOVER=4.
- IDLE:
  - start edge -> COUNTDOWN.
  - countdown loads COUNTDOWN_SECONDS; time_left loads GAME_SECONDS.
- COUNTDOWN:
  - Each tick_1s decrements countdown.
  - On the tick where countdown==1, countdown becomes 0 and the state moves to RUN on the same edge.
  - pause and start edges are ignored.
- RUN:
  - master_enable=1, combinationally from state.
  - Each tick_1s decrements time_left.
  - The tick that takes time_left 1->0 goes to GAMEOVER with win=1.
  - player_caught=1 in any RUN cycle goes to GAMEOVER with win=0.
  - If player_caught and the final tick coincide, the loss takes priority (win=0).
  - pause edge -> PAUSE.
- PAUSE:
  - master_enable=0; time_left frozen; ticks ignored; player_caught ignored.
  - pause edge or start edge -> RUN.
- GAMEOVER:
  - game_over=1; win held.
  - start edge -> IDLE; counters reload as on reset.
- Arbitration:
  - A req_* input high in a RUN cycle sets the matching pending flag. Requests in other states are discarded.
  - At most one grant per tick window. The window opens at each tick_1s in RUN.
  - The first cycle in which the window is open and a pending flag is set issues the grant.
  - That grant pulses for exactly 1 cycle, clears its pending flag and closes the window until the next tick_1s.
  - If both flags are pending, grant round-robin. Start after reset preferring blackout; thereafter grant the one not granted last time. The loser stays pending.
  - Leaving RUN clears both pending flags and closes the window.
  - A grant never fires in the same cycle as the transition out of RUN.
- Width rules:
  - All decrements saturate at 0; no wrap-around.
  - time_left is 8 bits unsigned.

Decomposition:
- Shared package game_pkg holds:
  - the state enum (IDLE, COUNTDOWN, RUN, PAUSE, GAMEOVER) and its 3-bit width;
  - default COUNTDOWN_SECONDS and GAME_SECONDS constants.
- One natural sub-module: button_edge (2-flop synchroniser plus rising-edge pulse), instanced twice.
- The arbiter stays inline; it is only a few flags.

Test Plan:
1. Reset, then start_btn rise: state=1 three cycles later, countdown=3; after 3 ticks, state=2, master_enable=1, time_left=180.
2. In RUN, 180 ticks with player_caught=0: time_left reaches 0, state=4, game_over=1, win=1, master_enable=0.
3. In RUN at time_left=50, pause edge then 5 ticks: time_left stays 50 and master_enable=0; second pause edge resumes, and the next tick gives time_left=49.
4. req_blackout and req_build both high in the same cycle after a tick: grant_blackout pulses once; grant_build pulses in the cycle after the next tick; neither pulses twice.
5. player_caught=1 in the same cycle as the tick taking time_left 1->0: state=4, win=0.
6. resetN low mid-RUN with req_build pending: outputs return to reset values immediately; after release and a new start, no stale grant_build appears.
